lc_otp_prog_requester: RTL and testbench
========================================

// Module: lc_otp_prog_requester
// PURPOSE
// - Life-cycle-side initiator of the LC->OTP state-programming handshake (lc_otp_program_req_t/_rsp_t).
// - Accepts one program command (target state + transition count) from the LC transition FSM.
// - Drives req to the fuse controller until the single-cycle ack returns, then reports done/err.
// - Sits in the LC controller between the transition FSM and the fuse_ctrl LC program port.
// PARAMETERS
// - TimeoutCycles  default 1024  cycles req may stay high before timeout_o is raised (>=2)
// - CntWidth       default vbits(TimeoutCycles+1)  timeout counter width (derived, not overridden)
// PORTS
// - clk_i            in   1              clock
// - rst_i            in   1              asynchronous, active-high reset
// - start_i          in   1              single-cycle command strobe; sampled only in IdleSt
// - state_i          in   LcStateWidth   target lc_state_e, captured on accepted start_i
// - count_i          in   LcCountWidth   target lc_cnt_e, captured on accepted start_i
// - otp_prog_req_o   out  struct         lc_otp_program_req_t {req, state, count} to fuse_ctrl
// - otp_prog_rsp_i   in   struct         lc_otp_program_rsp_t {err, ack} from fuse_ctrl
// - busy_o           out  1              command in flight (ReqSt)
// - done_o           out  1              one-cycle pulse: ack received with err=0
// - err_o            out  1              one-cycle pulse: ack received with err=1
// - timeout_o        out  1              sticky: req exceeded TimeoutCycles; cleared by next accepted start_i
// - fsm_err_o        out  1              sticky: illegal FSM state or ack while not requesting; reset-only clear
// BEHAVIOUR
// - Reset: FSM=IdleSt, req=0, state/count regs='0, counter=0, all status outputs 0.
// - IdleSt: start_i=1 -> capture state_i/count_i, clear timeout_o, counter=0, go ReqSt; req rises next cycle.
// - ReqSt: req=1; state/count held stable every cycle until ack (protocol invariant).
// - ReqSt & ack: go IdleSt; req=0 the following cycle; done_o or err_o pulses in the cycle after ack.
//   Latency start_i -> req = 1 cycle; ack -> done_o/err_o = 1 cycle; back-to-back start accepted the cycle done_o pulses.
// - Counter increments each ReqSt cycle, saturates at TimeoutCycles; on reaching it timeout_o=1.
//   Timeout does NOT drop req (would violate protocol); a late ack still completes normally.
// - start_i while busy_o=1: ignored, no capture, no status effect.
// - ack while IdleSt (spurious): fsm_err_o=1, no done/err pulse.
// - err bit ignored unless ack=1.
// - Illegal FSM encoding -> ErrorSt: req=0, busy_o=0, fsm_err_o=1, terminal until rst_i.
// - rst_i mid-request: req drops asynchronously, captured command lost; no done/err.
// - FSM states: IdleSt, ReqSt, ErrorSt; sparse encoding (Hamming distance >=3), default -> ErrorSt.
// STRUCTURE
// - otp_ctrl_pkg additions: lc_prog_req_state_e (sparse 5-bit enum: IdleSt, ReqSt, ErrorSt),
//   LcProgTimeoutDefault = 1024.
// - lc_otp_program_req_t/_rsp_t and lc_state_e/lc_cnt_e reused unchanged from existing packages.
// - Single flat module; timeout counter inline, no sub-module; FSM register via prim sparse-FSM flop.
// TESTING
// - Nominal: start_i with LcStTestUnlocked0/LcCnt1, ack err=0 at 5th req cycle -> req high 5 cycles
//   with stable payload, done_o pulse 1 cycle after ack, busy_o=0.
// - Error ack: ack err=1 after 3 cycles -> err_o single pulse, done_o stays 0, req low next cycle.
// - Timeout: TimeoutCycles=8, no ack for 20 cycles -> timeout_o=1 at 8th req cycle, req still 1;
//   ack at cycle 20 -> done_o pulse; next start_i clears timeout_o.
// - Busy start: second start_i with different state_i during ReqSt -> payload unchanged, one done_o only.
// - Spurious ack in IdleSt -> fsm_err_o=1, done_o/err_o=0; force illegal FSM code -> req=0, fsm_err_o=1.
// - Reset mid-request: rst_i asserted while req=1 -> req=0 immediately, no pulse after release.

Source files
------------

// File: rtl/lc_otp_prog_requester_pkg.sv
// rtl/lc_otp_prog_requester_pkg.sv - types and constants for the LC->OTP program requester
package lc_otp_prog_requester_pkg;

    localparam int LcStateWidth         = 16;
    localparam int LcCountWidth         = 8;
    localparam int LcProgStateWidth     = 5;
    localparam int LcProgTimeoutDefault = 1024;

    typedef enum logic [LcStateWidth-1:0] {
        LcStRaw           = 16'h0000,
        LcStTestUnlocked0 = 16'h1a2b,
        LcStDev           = 16'h3c4d,
        LcStProd          = 16'h5e6f,
        LcStRma           = 16'h7081,
        LcStScrap         = 16'h92a3
    } lc_state_e;

    typedef enum logic [LcCountWidth-1:0] {
        LcCnt0 = 8'h00,
        LcCnt1 = 8'h15,
        LcCnt2 = 8'h2a,
        LcCnt3 = 8'h3f
    } lc_cnt_e;

    typedef struct packed {
        logic      req;
        lc_state_e state;
        lc_cnt_e   count;
    } lc_otp_program_req_t;

    typedef struct packed {
        logic err;
        logic ack;
    } lc_otp_program_rsp_t;

    // Pairwise Hamming distance of 3 or more between all legal codes.
    typedef enum logic [LcProgStateWidth-1:0] {
        IdleSt  = 5'b00111,
        ReqSt   = 5'b11100,
        ErrorSt = 5'b11011
    } lc_prog_req_state_e;

endpackage

// File: rtl/lc_otp_prog_requester_sparse_flop.sv
// rtl/lc_otp_prog_requester_sparse_flop.sv - state register for sparse-encoded FSMs
module lc_otp_prog_requester_sparse_flop #(
    parameter int               Width      = 5,
    parameter logic [Width-1:0] ResetValue = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [Width-1:0] state_d_i,
    output logic [Width-1:0] state_q_o
);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q_o <= ResetValue;
        end else begin
            state_q_o <= state_d_i;
        end
    end

endmodule

// File: rtl/lc_otp_prog_requester.sv
// rtl/lc_otp_prog_requester.sv - LC-side initiator of the OTP state-programming handshake
module lc_otp_prog_requester
    import lc_otp_prog_requester_pkg::*;
#(
    parameter int TimeoutCycles = LcProgTimeoutDefault
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic [LcStateWidth-1:0] state_i,
    input  logic [LcCountWidth-1:0] count_i,
    output lc_otp_program_req_t     otp_prog_req_o,
    input  lc_otp_program_rsp_t     otp_prog_rsp_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o,
    output logic                    timeout_o,
    output logic                    fsm_err_o
);

    localparam int                  CntWidth = $clog2(TimeoutCycles + 1);
    localparam logic [CntWidth-1:0] CntMax   = CntWidth'(TimeoutCycles);
    // Flag is registered, so arm it one cycle early to land on the TimeoutCycles-th req cycle.
    localparam logic [CntWidth-1:0] CntArm   = CntWidth'(TimeoutCycles - 2);

    logic [LcProgStateWidth-1:0] state_raw;
    logic [LcProgStateWidth-1:0] state_d;

    logic                    accept;
    logic                    in_req;
    logic                    illegal_state;
    logic                    ack;
    logic                    spurious_ack;

    logic [LcStateWidth-1:0] prog_state_q;
    logic [LcCountWidth-1:0] prog_count_q;
    logic [CntWidth-1:0]     cnt_q;
    logic                    done_q;
    logic                    err_q;
    logic                    timeout_q;
    logic                    fsm_err_q;

    assign ack          = otp_prog_rsp_i.ack;
    assign spurious_ack = ack & ~in_req;

    always_comb begin
        state_d       = ErrorSt;
        accept        = 1'b0;
        in_req        = 1'b0;
        illegal_state = 1'b0;
        case (state_raw)
            IdleSt: begin
                state_d = IdleSt;
                if (start_i) begin
                    state_d = ReqSt;
                    accept  = 1'b1;
                end
            end
            ReqSt: begin
                in_req  = 1'b1;
                state_d = ack ? IdleSt : ReqSt;
            end
            ErrorSt: begin
                state_d       = ErrorSt;
                illegal_state = 1'b1;
            end
            default: begin
                state_d       = ErrorSt;
                illegal_state = 1'b1;
            end
        endcase
    end

    lc_otp_prog_requester_sparse_flop #(
        .Width      (LcProgStateWidth),
        .ResetValue (IdleSt)
    ) u_state_regs (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .state_d_i (state_d),
        .state_q_o (state_raw)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prog_state_q <= '0;
            prog_count_q <= '0;
        end else if (accept) begin
            prog_state_q <= state_i;
            prog_count_q <= count_i;
        end
    end

    // Timeout never drops req; a late ack still completes the transaction.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else if (accept) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else if (in_req) begin
            if (cnt_q != CntMax) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (cnt_q >= CntArm) begin
                timeout_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            fsm_err_q <= 1'b0;
        end else begin
            done_q    <= in_req & ack & ~otp_prog_rsp_i.err;
            err_q     <= in_req & ack & otp_prog_rsp_i.err;
            fsm_err_q <= fsm_err_q | spurious_ack | illegal_state;
        end
    end

    always_comb begin
        otp_prog_req_o       = '0;
        otp_prog_req_o.req   = in_req;
        otp_prog_req_o.state = lc_state_e'(prog_state_q);
        otp_prog_req_o.count = lc_cnt_e'(prog_count_q);
    end

    assign busy_o    = in_req;
    assign done_o    = done_q;
    assign err_o     = err_q;
    assign timeout_o = timeout_q;
    assign fsm_err_o = fsm_err_q;

endmodule

// File: tb/tb_lc_otp_prog_requester.sv
// tb/tb_lc_otp_prog_requester.sv - self-checking bench for lc_otp_prog_requester
module tb_lc_otp_prog_requester;
    import lc_otp_prog_requester_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    start = 1'b0;
    logic [LcStateWidth-1:0] st_in = '0;
    logic [LcCountWidth-1:0] cnt_in = '0;
    lc_otp_program_req_t     req_o;
    lc_otp_program_rsp_t     rsp = '0;
    logic                    busy, done, err, timeout, fsm_err;

    int n_pass  = 0;
    int n_total = 0;

    logic [23:0] exp_q[$];
    logic [23:0] last_payload = '0;

    lc_otp_prog_requester #(.TimeoutCycles(8)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .start_i        (start),
        .state_i        (st_in),
        .count_i        (cnt_in),
        .otp_prog_req_o (req_o),
        .otp_prog_rsp_i (rsp),
        .busy_o         (busy),
        .done_o         (done),
        .err_o          (err),
        .timeout_o      (timeout),
        .fsm_err_o      (fsm_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    typedef struct {
        logic                    start;
        logic [LcStateWidth-1:0] st;
        logic [LcCountWidth-1:0] cnt;
        logic                    ack;
        logic                    aerr;
        logic                    e_req;
        logic                    e_busy;
        logic                    e_done;
        logic                    e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic s, input logic [15:0] sv, input logic [7:0] cv,
                                input logic a, input logic ae, input logic rq,
                                input logic bz, input logic dn, input logic er);
        vec_t v;
        v.start = s; v.st = sv; v.cnt = cv; v.ack = a; v.aerr = ae;
        v.e_req = rq; v.e_busy = bz; v.e_done = dn; v.e_err = er;
        return v;
    endfunction

    // Scoreboard: payload must match the oldest accepted command; each pulse retires one command.
    always @(negedge clk) begin
        if (!rst) begin
            if (req_o.req) begin
                check("sb_req_has_cmd", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    check("sb_payload", {req_o.state, req_o.count}, exp_q[0]);
                end
                last_payload = {req_o.state, req_o.count};
            end
            if (done || err) begin
                check("sb_pulse_has_cmd", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    check("sb_retired_payload", last_payload, exp_q.pop_front());
                end
            end
        end
    end

    task automatic step_drive(input logic s, input logic [15:0] sv, input logic [7:0] cv,
                              input logic a, input logic ae);
        @(posedge clk);
        #1;
        start   = s;
        st_in   = s ? sv : 16'($urandom);
        cnt_in  = s ? cv : 8'($urandom);
        rsp.ack = a;
        rsp.err = ae;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        // Nominal: 5 req cycles, ack err=0
        vecs.push_back(mk(1, LcStTestUnlocked0, LcCnt1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        // Error ack after 3 cycles
        vecs.push_back(mk(1, LcStDev, LcCnt2, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        // Start while busy ignored; back-to-back start on the done pulse; err without ack ignored
        vecs.push_back(mk(1, LcStProd, LcCnt3, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, LcStRma, LcCnt1, 0, 0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 1, 1, 0, 0));
        vecs.push_back(mk(1, LcStTestUnlocked0, LcCnt2, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req", req_o.req, 0);
        check("rst_payload", {req_o.state, req_o.count}, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_timeout", timeout, 0);
        check("rst_fsm_err", fsm_err, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        foreach (vecs[i]) begin
            step_drive(vecs[i].start, vecs[i].st, vecs[i].cnt, vecs[i].ack, vecs[i].aerr);
            if (vecs[i].start && !vecs[i].e_busy) exp_q.push_back({vecs[i].st, vecs[i].cnt});
            @(negedge clk);
            check($sformatf("v%0d_req", i), req_o.req, vecs[i].e_req);
            check($sformatf("v%0d_busy", i), busy, vecs[i].e_busy);
            check($sformatf("v%0d_done", i), done, vecs[i].e_done);
            check($sformatf("v%0d_err", i), err, vecs[i].e_err);
            check($sformatf("v%0d_fsm_err", i), fsm_err, 0);
        end

        // Timeout at 8th req cycle, req held, late ack completes
        step_drive(1, LcStProd, LcCnt2, 0, 0);
        exp_q.push_back({LcStProd, LcCnt2});
        for (int k = 1; k <= 20; k++) begin
            step_drive(0, 0, 0, k == 20, 0);
            @(negedge clk);
            check($sformatf("to_req_c%0d", k), req_o.req, 1);
            check($sformatf("to_flag_c%0d", k), timeout, 32'(k >= 8));
        end
        step_drive(1, LcStScrap, LcCnt3, 0, 0);
        exp_q.push_back({LcStScrap, LcCnt3});
        @(negedge clk);
        check("to_late_done", done, 1);
        check("to_sticky", timeout, 1);
        check("to_req_low", req_o.req, 0);
        step_drive(0, 0, 0, 1, 0);
        @(negedge clk);
        check("to_cleared", timeout, 0);
        check("to_new_req", req_o.req, 1);
        step_drive(0, 0, 0, 0, 0);
        @(negedge clk);
        check("to_new_done", done, 1);

        // Spurious ack in idle
        step_drive(0, 0, 0, 1, 1);
        step_drive(0, 0, 0, 0, 0);
        @(negedge clk);
        check("spur_fsm_err", fsm_err, 1);
        check("spur_done", done, 0);
        check("spur_err", err, 0);

        // Illegal FSM encoding lands in a terminal error state
        @(posedge clk);
        #1 force dut.state_raw = 5'b00000;
        @(negedge clk);
        check("ill_req_now", req_o.req, 0);
        @(posedge clk);
        #1 release dut.state_raw;
        start = 1'b1;
        st_in = LcStDev;
        @(negedge clk);
        check("ill_fsm_err", fsm_err, 1);
        check("ill_busy", busy, 0);
        step_drive(0, 0, 0, 0, 0);
        @(negedge clk);
        check("ill_start_ignored", req_o.req, 0);
        check("ill_state_terminal", dut.state_raw, ErrorSt);

        // Reset mid-request
        #1 rst = 1'b1;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst2_fsm_err", fsm_err, 0);
        step_drive(1, LcStRma, LcCnt1, 0, 0);
        exp_q.push_back({LcStRma, LcCnt1});
        step_drive(0, 0, 0, 0, 0);
        @(negedge clk);
        check("mid_req_high", req_o.req, 1);
        #2 rst = 1'b1;
        #1;
        check("mid_req_async_low", req_o.req, 0);
        check("mid_busy_low", busy, 0);
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step_drive(0, 0, 0, 0, 0);
            @(negedge clk);
            check($sformatf("post_rst_done_%0d", k), done, 0);
            check($sformatf("post_rst_err_%0d", k), err, 0);
            check($sformatf("post_rst_req_%0d", k), req_o.req, 0);
        end

        check("sb_drained", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
